// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory stage: address/write-source selects, stack ops, FSM states.
// No logic of its own.
// Feature macro affecting users of this package: MEMORY_STAGE_STACK_CHECK_EN.
package mem_stage_pkg;

    localparam int ADDR_W_DEFAULT   = 11;
    localparam int SP_RESET_DEFAULT = (1 << ADDR_W_DEFAULT) - 1;

    typedef enum logic [1:0] {
        ASEL_RESULT  = 2'b00,
        ASEL_SP      = 2'b01,
        ASEL_SP_P1   = 2'b10,
        ASEL_RESULT2 = 2'b11
    } addr_sel_t;

    typedef enum logic [1:0] {
        WSRC_RD2   = 2'b00,
        WSRC_RD1   = 2'b01,
        WSRC_PC    = 2'b10,
        WSRC_FLAGS = 2'b11
    } wsrc_sel_t;

    typedef enum logic [2:0] {
        SP_HOLD = 3'd0,
        SP_INC1 = 3'd1,
        SP_INC2 = 3'd2,
        SP_DEC1 = 3'd3,
        SP_DEC2 = 3'd4
    } sp_op_t;

    typedef enum logic [1:0] {
        CHK_NONE     = 2'd0,
        CHK_PUSH     = 2'd1,
        CHK_POP      = 2'd2,
        CHK_POP_WIDE = 2'd3
    } sp_chk_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BEAT2 = 1'b1
    } state_t;

endpackage

// File: rtl/stack_pointer_unit.sv
// Stack pointer register with +1/+2/-1/-2 update and bounds compare (MEMORY_STAGE_STACK_CHECK_EN).
// Latency: SP updates on the clock after op; fault is combinational from chk and current SP.
// Backpressure: none; the caller forces op to SP_HOLD when an access is suppressed.
module stack_pointer_unit
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int SP_RESET = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        op,
    input  logic [1:0]        chk,
    output logic [ADDR_W-1:0] sp,
    output logic [ADDR_W-1:0] sp_plus1,
    output logic [ADDR_W-1:0] sp_plus2,
    output logic [ADDR_W-1:0] sp_minus1,
    output logic              fault
);

    localparam logic [ADDR_W-1:0] SP_TOP = ADDR_W'(SP_RESET);

    // Plain ADDR_W-bit arithmetic gives the modulo wrap for free.
    assign sp_plus1  = sp + ADDR_W'(1);
    assign sp_plus2  = sp + ADDR_W'(2);
    assign sp_minus1 = sp - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= SP_TOP;
        end else begin
            case (op)
                SP_INC1: sp <= sp_plus1;
                SP_INC2: sp <= sp_plus2;
                SP_DEC1: sp <= sp_minus1;
                SP_DEC2: sp <= sp - ADDR_W'(2);
                default: sp <= sp;
            endcase
        end
    end

`ifdef MEMORY_STAGE_STACK_CHECK_EN
    always_comb begin
        case (chk)
            CHK_PUSH:     fault = (sp == '0);
            CHK_POP:      fault = (sp == SP_TOP);
            CHK_POP_WIDE: fault = (sp >= SP_TOP - ADDR_W'(1));
            default:      fault = 1'b0;
        endcase
    end
`else
    logic chk_unused;
    assign chk_unused = ^chk;
    assign fault      = 1'b0;
`endif

endmodule

// File: rtl/memory_stage.sv
// MEM stage: drives data memory, owns SP, splits 32-bit PC push/pop into two beats (MEMORY_STAGE_STACK_CHECK_EN).
// Latency: results registered into MEM->WB one cycle after the access; wide ops take two cycles.
// Backpressure: stall_out asserted combinationally during the first beat of a wide push/pop.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEFAULT,
    parameter int SP_RESET = (1 << ADDR_W) - 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result,
    input  logic [31:0]       PC,
    input  logic [15:0]       LDM_value,
    input  logic [15:0]       read_data1,
    input  logic [15:0]       read_data2,
    input  logic [2:0]        flag_register,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic              reg_write,
    input  logic              pc_enable,
    input  logic [1:0]        wb_sel,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic [15:0]       dmem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [15:0]       dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    output logic              stall_out,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       result_out,
    output logic [15:0]       LDM_value_out,
    output logic              reg_write_out,
    output logic              pc_enable_out,
    output logic [1:0]        wb_sel_out,
    output logic [31:0]       popped_pc_out,
    output logic [2:0]        conditions_from_memory_pop,
    output logic              stack_fault
);

    state_t            state, next_state;
    sp_op_t            sp_op;
    sp_chk_t           sp_chk;
    logic [ADDR_W-1:0] sp, sp_plus1, sp_plus2, sp_minus1;
    logic              sp_fault;
    logic [ADDR_W-1:0] sel_addr;
    logic [15:0]       sel_wdata;
    logic [15:0]       low_hold;
    logic              beat_pop;
    logic              bubble, hold_low, pop_done, load_data, narrow_pop;

    stack_pointer_unit #(
        .ADDR_W   (ADDR_W),
        .SP_RESET (SP_RESET)
    ) u_sp (
        .clk       (clk),
        .reset     (reset),
        .op        (sp_op),
        .chk       (sp_chk),
        .sp        (sp),
        .sp_plus1  (sp_plus1),
        .sp_plus2  (sp_plus2),
        .sp_minus1 (sp_minus1),
        .fault     (sp_fault)
    );

    always_comb begin
        case (memory_address_select)
            ASEL_SP:    sel_addr = sp;
            ASEL_SP_P1: sel_addr = sp_plus1;
            default:    sel_addr = result[ADDR_W-1:0];
        endcase
        case (memory_write_src_select)
            WSRC_RD2:   sel_wdata = read_data2;
            WSRC_RD1:   sel_wdata = read_data1;
            WSRC_PC:    sel_wdata = PC[15:0];
            default:    sel_wdata = {13'b0, flag_register};
        endcase
    end

    always_comb begin
        next_state = state;
        stall_out  = 1'b0;
        dmem_we    = 1'b0;
        dmem_re    = 1'b0;
        dmem_addr  = sel_addr;
        dmem_wdata = sel_wdata;
        sp_op      = SP_HOLD;
        sp_chk     = CHK_NONE;
        bubble     = 1'b0;
        hold_low   = 1'b0;
        pop_done   = 1'b0;
        load_data  = 1'b0;
        narrow_pop = 1'b0;
        if (!reset) begin
            case (state)
                ST_IDLE: begin
                    // Push takes priority over pop; write over read.
                    if (mem_push) begin
                        sp_chk = CHK_PUSH;
                        if (sp_fault) begin
                            bubble = 1'b1;
                        end else begin
                            dmem_we   = 1'b1;
                            dmem_addr = sp;
                            if (memory_write_src_select == WSRC_PC) begin
                                dmem_wdata = PC[31:16];
                                next_state = ST_BEAT2;
                                stall_out  = 1'b1;
                                bubble     = 1'b1;
                            end else begin
                                sp_op = SP_DEC1;
                            end
                        end
                    end else if (mem_pop) begin
                        sp_chk = pc_enable ? CHK_POP_WIDE : CHK_POP;
                        if (sp_fault) begin
                            bubble = 1'b1;
                        end else begin
                            dmem_re   = 1'b1;
                            dmem_addr = sp_plus1;
                            if (pc_enable) begin
                                next_state = ST_BEAT2;
                                stall_out  = 1'b1;
                                bubble     = 1'b1;
                                hold_low   = 1'b1;
                            end else begin
                                sp_op      = SP_INC1;
                                load_data  = 1'b1;
                                narrow_pop = 1'b1;
                            end
                        end
                    end else if (mem_write) begin
                        dmem_we = 1'b1;
                    end else if (mem_read) begin
                        dmem_re   = 1'b1;
                        load_data = 1'b1;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    if (beat_pop) begin
                        dmem_re   = 1'b1;
                        dmem_addr = sp_plus2;
                        sp_op     = SP_INC2;
                        pop_done  = 1'b1;
                    end else begin
                        sp_chk = CHK_PUSH;
                        if (sp_fault) begin
                            bubble = 1'b1;
                        end else begin
                            dmem_we    = 1'b1;
                            dmem_addr  = sp_minus1;
                            dmem_wdata = PC[15:0];
                            sp_op      = SP_DEC2;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                      <= ST_IDLE;
            beat_pop                   <= 1'b0;
            low_hold                   <= '0;
            mem_data_out               <= '0;
            result_out                 <= '0;
            LDM_value_out              <= '0;
            reg_write_out              <= 1'b0;
            pc_enable_out              <= 1'b0;
            wb_sel_out                 <= '0;
            popped_pc_out              <= '0;
            conditions_from_memory_pop <= '0;
        end else begin
            state         <= next_state;
            result_out    <= result;
            LDM_value_out <= LDM_value;
            wb_sel_out    <= wb_sel;
            reg_write_out <= reg_write & ~bubble;
            pc_enable_out <= pop_done | (pc_enable & ~bubble);
            if (state == ST_IDLE) begin
                beat_pop <= hold_low;
            end
            if (hold_low) begin
                low_hold <= dmem_rdata;
            end
            if (load_data) begin
                mem_data_out <= dmem_rdata;
            end
            if (narrow_pop) begin
                conditions_from_memory_pop <= dmem_rdata[2:0];
            end
            if (pop_done) begin
                popped_pc_out <= {dmem_rdata, low_hold};
            end
        end
    end

`ifdef MEMORY_STAGE_STACK_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stack_fault <= 1'b0;
        end else if (sp_fault) begin
            stack_fault <= 1'b1;
        end
    end
`else
    assign stack_fault = 1'b0;
`endif

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage with a behavioural data memory and an expected-value queue.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] result, LDM_value, read_data1, read_data2, dmem_rdata;
    logic [31:0] PC;
    logic [2:0]  flag_register;
    logic        mem_read, mem_write, mem_push, mem_pop, reg_write, pc_enable;
    logic [1:0]  wb_sel, memory_address_select, memory_write_src_select;
    logic [10:0] dmem_addr;
    logic [15:0] dmem_wdata, mem_data_out, result_out, LDM_value_out;
    logic        dmem_we, dmem_re, stall_out, reg_write_out, pc_enable_out, stack_fault;
    logic [1:0]  wb_sel_out;
    logic [31:0] popped_pc_out;
    logic [2:0]  conditions_from_memory_pop;

    logic [15:0] mem [0:2047] = '{default: 16'h0000};

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    initial forever #5 clk = ~clk;

    assign dmem_rdata = mem[dmem_addr];
    always @(posedge clk) if (dmem_we) mem[dmem_addr] <= dmem_wdata;

    memory_stage dut (
        .clk(clk), .reset(reset), .result(result), .PC(PC), .LDM_value(LDM_value),
        .read_data1(read_data1), .read_data2(read_data2), .flag_register(flag_register),
        .mem_read(mem_read), .mem_write(mem_write), .mem_push(mem_push), .mem_pop(mem_pop),
        .reg_write(reg_write), .pc_enable(pc_enable), .wb_sel(wb_sel),
        .memory_address_select(memory_address_select),
        .memory_write_src_select(memory_write_src_select), .dmem_rdata(dmem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
        .stall_out(stall_out), .mem_data_out(mem_data_out), .result_out(result_out),
        .LDM_value_out(LDM_value_out), .reg_write_out(reg_write_out),
        .pc_enable_out(pc_enable_out), .wb_sel_out(wb_sel_out), .popped_pc_out(popped_pc_out),
        .conditions_from_memory_pop(conditions_from_memory_pop), .stack_fault(stack_fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        sb.push_back('{tag, val});
    endtask

    task automatic sb_check(input logic [31:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL sb_empty: observed %0h expected queued entry", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        result = '0; PC = '0; LDM_value = '0; read_data1 = '0; read_data2 = '0;
        flag_register = '0; mem_read = 0; mem_write = 0; mem_push = 0; mem_pop = 0;
        reg_write = 0; pc_enable = 0; wb_sel = '0; memory_address_select = '0;
        memory_write_src_select = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset, then idle
        clear();
        reset = 1'b1;
        mem_push = 1'b1; read_data1 = 16'h1111; memory_write_src_select = 2'b01;
        #1;
        chk("rst_we", 32'(dmem_we), 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);
        tick(); tick();
        reset = 1'b0;
        clear();
        tick();
        chk("idle_sp", 32'(dut.sp), 32'h7FF);
        chk("idle_mem_data", 32'(mem_data_out), 32'h0);
        chk("idle_reg_write", 32'(reg_write_out), 32'h0);
        chk("idle_pc_en", 32'(pc_enable_out), 32'h0);
        chk("idle_popped_pc", popped_pc_out, 32'h0);
        chk("idle_stall", 32'(stall_out), 32'h0);
        chk("idle_fault", 32'(stack_fault), 32'h0);

        // 2: narrow push then pop
        mem_push = 1'b1; memory_write_src_select = 2'b01; read_data1 = 16'hBEEF;
        #1;
        chk("push_we", 32'(dmem_we), 32'h1);
        chk("push_addr", 32'(dmem_addr), 32'h7FF);
        chk("push_wdata", 32'(dmem_wdata), 32'hBEEF);
        tick();
        chk("push_sp", 32'(dut.sp), 32'h7FE);
        chk("push_mem", 32'(mem[11'h7FF]), 32'hBEEF);
        clear();
        mem_pop = 1'b1; reg_write = 1'b1; wb_sel = 2'b01;
        #1;
        chk("pop_re", 32'(dmem_re), 32'h1);
        chk("pop_addr", 32'(dmem_addr), 32'h7FF);
        sb_push("pop_data", 32'hBEEF);
        sb_push("pop_cond", 32'h7);
        tick();
        sb_check(32'(mem_data_out));
        sb_check(32'(conditions_from_memory_pop));
        chk("pop_sp", 32'(dut.sp), 32'h7FF);
        chk("pop_reg_write", 32'(reg_write_out), 32'h1);
        chk("pop_wb_sel", 32'(wb_sel_out), 32'h1);

        // 3: CALL -> wide push over two beats
        clear();
        mem_push = 1'b1; memory_write_src_select = 2'b10; PC = 32'h0001_2345;
        reg_write = 1'b1; result = 16'h1234;
        #1;
        chk("call_b1_stall", 32'(stall_out), 32'h1);
        chk("call_b1_addr", 32'(dmem_addr), 32'h7FF);
        chk("call_b1_wdata", 32'(dmem_wdata), 32'h0001);
        tick();
        chk("call_bubble", 32'(reg_write_out), 32'h0);
        chk("call_b1_sp", 32'(dut.sp), 32'h7FF);
        chk("call_b2_stall", 32'(stall_out), 32'h0);
        chk("call_b2_addr", 32'(dmem_addr), 32'h7FE);
        chk("call_b2_wdata", 32'(dmem_wdata), 32'h2345);
        sb_push("call_result", 32'h1234);
        tick();
        sb_check(32'(result_out));
        chk("call_b2_reg_write", 32'(reg_write_out), 32'h1);
        chk("call_sp", 32'(dut.sp), 32'h7FD);
        chk("call_mem_hi", 32'(mem[11'h7FF]), 32'h0001);
        chk("call_mem_lo", 32'(mem[11'h7FE]), 32'h2345);

        // 4: RET -> wide pop
        clear();
        mem_pop = 1'b1; pc_enable = 1'b1;
        #1;
        chk("ret_b1_stall", 32'(stall_out), 32'h1);
        chk("ret_b1_addr", 32'(dmem_addr), 32'h7FE);
        tick();
        chk("ret_bubble_pc_en", 32'(pc_enable_out), 32'h0);
        chk("ret_b2_stall", 32'(stall_out), 32'h0);
        chk("ret_b2_addr", 32'(dmem_addr), 32'h7FF);
        sb_push("ret_popped_pc", 32'h0001_2345);
        tick();
        sb_check(popped_pc_out);
        chk("ret_pc_en", 32'(pc_enable_out), 32'h1);
        chk("ret_sp", 32'(dut.sp), 32'h7FF);

        // 5: STD/LDD, write beats read, upper address bits ignored, push beats pop
        clear();
        mem_write = 1'b1; mem_read = 1'b1; result = 16'h0010; read_data2 = 16'h00AA;
        #1;
        chk("std_we", 32'(dmem_we), 32'h1);
        chk("std_re_blocked", 32'(dmem_re), 32'h0);
        chk("std_addr", 32'(dmem_addr), 32'h010);
        tick();
        chk("std_mem", 32'(mem[11'h010]), 32'h00AA);
        clear();
        mem_read = 1'b1; result = 16'hF810; LDM_value = 16'h5A5A;
        #1;
        chk("ldd_addr_trunc", 32'(dmem_addr), 32'h010);
        sb_push("ldd_data", 32'h00AA);
        sb_push("ldm_pass", 32'h5A5A);
        tick();
        sb_check(32'(mem_data_out));
        sb_check(32'(LDM_value_out));
        clear();
        mem_push = 1'b1; mem_pop = 1'b1; memory_write_src_select = 2'b01; read_data1 = 16'h1357;
        #1;
        chk("pp_we", 32'(dmem_we), 32'h1);
        chk("pp_re", 32'(dmem_re), 32'h0);
        chk("pp_addr", 32'(dmem_addr), 32'h7FF);
        tick();
        chk("pp_sp", 32'(dut.sp), 32'h7FE);
        chk("pp_mem", 32'(mem[11'h7FF]), 32'h1357);
        clear();
        mem_pop = 1'b1;
        sb_push("pp_restore", 32'h1357);
        tick();
        sb_check(32'(mem_data_out));
        chk("pp_restore_sp", 32'(dut.sp), 32'h7FF);

        // 6: pop at top of stack
        clear();
        mem_pop = 1'b1; reg_write = 1'b1;
        #1;
`ifdef MEMORY_STAGE_STACK_CHECK_EN
        chk("ovf_re", 32'(dmem_re), 32'h0);
        tick();
        chk("ovf_sp", 32'(dut.sp), 32'h7FF);
        chk("ovf_fault", 32'(stack_fault), 32'h1);
        chk("ovf_bubble", 32'(reg_write_out), 32'h0);
`else
        chk("wrap_re", 32'(dmem_re), 32'h1);
        chk("wrap_addr", 32'(dmem_addr), 32'h000);
        tick();
        chk("wrap_sp", 32'(dut.sp), 32'h000);
        chk("wrap_fault", 32'(stack_fault), 32'h0);
`endif
        clear();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst2_sp", 32'(dut.sp), 32'h7FF);
        chk("rst2_fault", 32'(stack_fault), 32'h0);

        // reset while in the second beat of a CALL
        mem_push = 1'b1; memory_write_src_select = 2'b10; PC = 32'hAAAA_5555;
        #1;
        chk("abort_b1_stall", 32'(stall_out), 32'h1);
        tick();
        reset = 1'b1;
        #1;
        chk("abort_rst_we", 32'(dmem_we), 32'h0);
        chk("abort_rst_stall", 32'(stall_out), 32'h0);
        tick();
        reset = 1'b0;
        clear();
        chk("abort_sp", 32'(dut.sp), 32'h7FF);
        chk("abort_mem_kept", 32'(mem[11'h7FF]), 32'hAAAA);
        mem_push = 1'b1; memory_write_src_select = 2'b01; read_data1 = 16'h0C0C;
        #1;
        chk("abort_idle_addr", 32'(dmem_addr), 32'h7FF);
        chk("abort_idle_stall", 32'(stall_out), 32'h0);
        tick();
        clear();
        chk("abort_idle_sp", 32'(dut.sp), 32'h7FE);
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
